// File: rtl/spi_master.sv
// Mode 0 SPI master, one word per start; done pulses CLK_DIV*(2*DATA_WIDTH+2) clks after accept; start is ignored while busy.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first in both directions (timing unchanged).
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_next;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  first_bit;
  logic                  next_bit;
  logic                  div_end;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign first_bit = masterDataToSend[0];
  assign next_bit  = tx_shift[1];
  assign tx_next   = tx_shift >> 1;
  assign rx_next   = {MISO, rx_shift[DATA_WIDTH-1:1]};
`else
  assign first_bit = masterDataToSend[DATA_WIDTH-1];
  assign next_bit  = tx_shift[DATA_WIDTH-2];
  assign tx_next   = tx_shift << 1;
  assign rx_next   = {rx_shift[DATA_WIDTH-2:0], MISO};
`endif

  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      div_cnt            <= '0;
      edge_cnt           <= '0;
      tx_shift           <= '0;
      rx_shift           <= '0;
      masterDataReceived <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      sclk               <= 1'b0;
      CS                 <= 1'b1;
      MOSI               <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tx_shift <= masterDataToSend;
            CS       <= 1'b0;
            MOSI     <= first_bit;
            busy     <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= S_XFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (div_end) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (!sclk) begin
              rx_shift <= rx_next;
            end else if (edge_cnt != EDGE_LAST) begin
              // The last falling edge leaves MOSI on the final bit.
              tx_shift <= tx_next;
              MOSI     <= next_bit;
            end
            if (sclk && edge_cnt == EDGE_LAST) begin
              state <= S_HOLD;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (div_end) begin
            div_cnt            <= '0;
            CS                 <= 1'b1;
            MOSI               <= 1'b0;
            done               <= 1'b1;
            masterDataReceived <= rx_shift;
            state              <= S_DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) with a bit-level SPI slave model each.
module tb_spi_master;
  localparam int DW = 8;
  localparam int L0 = 2 * (2 * DW + 2);
  localparam int L1 = 1 * (2 * DW + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [7:0] data0, data1, rx0, rx1;
  logic       busy0, busy1, done0, done1, sclk0, sclk1, cs0, cs1, mosi0, mosi1, miso0, miso1;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(2)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .masterDataToSend(data0),
    .masterDataReceived(rx0), .busy(busy0), .done(done0), .sclk(sclk0),
    .CS(cs0), .MOSI(mosi0), .MISO(miso0));

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .masterDataToSend(data1),
    .masterDataReceived(rx1), .busy(busy1), .done(done1), .sclk(sclk1),
    .CS(cs1), .MOSI(mosi1), .MISO(miso1));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Order of bits on the wire: bit 7 of the result travels first.
  function automatic logic [7:0] wire_order(input logic [7:0] w);
    logic [7:0] r;
    r = w;
`ifdef SPI_MASTER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`endif
    return r;
  endfunction

  typedef struct packed {
    logic [7:0] mosi;
    logic [7:0] rx;
  } exp_t;

  exp_t       exp_q0[$], exp_q1[$];
  logic [7:0] resp_q0[$], resp_q1[$];
  exp_t       e0, e1;

  // Slave models: load a response when CS falls, shift out on falling sclk, capture MOSI on rising sclk.
  logic [7:0] s0_word = 8'h00, s0_cap = 8'h00, s1_word = 8'h00, s1_cap = 8'h00;
  int s0_rises = 0, s0_falls = 0, s1_rises = 0, s1_falls = 0;
  int cs_viol0 = 0, cs_viol1 = 0;
  longint last_rise1 = 0;

  assign miso0 = (s0_falls < 8) ? s0_word[3'(7 - s0_falls)] : 1'b0;
  assign miso1 = (s1_falls < 8) ? s1_word[3'(7 - s1_falls)] : 1'b0;

  always @(negedge cs0) begin
    s0_word = 8'h00;
    if (resp_q0.size() > 0) s0_word = wire_order(resp_q0.pop_front());
    s0_cap = 8'h00; s0_rises = 0; s0_falls = 0;
  end
  always @(posedge sclk0) begin
    s0_cap = {s0_cap[6:0], mosi0};
    s0_rises++;
    if (cs0 !== 1'b0) cs_viol0++;
  end
  always @(negedge sclk0) s0_falls++;

  always @(negedge cs1) begin
    s1_word = 8'h00;
    if (resp_q1.size() > 0) s1_word = wire_order(resp_q1.pop_front());
    s1_cap = 8'h00; s1_rises = 0; s1_falls = 0;
  end
  always @(posedge sclk1) begin
    if (s1_rises > 0) check("sclk1_period", 32'($time - last_rise1), 32'd20);
    last_rise1 = $time;
    s1_cap = {s1_cap[6:0], mosi1};
    s1_rises++;
    if (cs1 !== 1'b0) cs_viol1++;
  end
  always @(negedge sclk1) s1_falls++;

  // Monitor: sampled on the falling clk edge, pops the scoreboard on each done.
  int cyc = 0, acc0 = 0, acc1 = 0, n_acc0 = 0, n_acc1 = 0, n_done0 = 0, n_done1 = 0, gap1 = 0;
  logic busy0_q = 1'b0, busy1_q = 1'b0, done0_q = 1'b0, done1_q = 1'b0, cs1_q = 1'b1;
  bit seen1 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      if (busy0 && !busy0_q) begin acc0 = cyc; n_acc0++; end
      if (busy1 && !busy1_q) begin acc1 = cyc; n_acc1++; end
      if (done0_q) check("done0_width", 32'(done0), 32'd0);
      if (done1_q) check("done1_width", 32'(done1), 32'd0);
      if (done0) begin
        n_done0++;
        check("done0_expected", 32'(exp_q0.size() > 0), 32'd1);
        if (exp_q0.size() > 0) begin
          e0 = exp_q0.pop_front();
          check("rx0", 32'(rx0), 32'(e0.rx));
          check("mosi0_bits", 32'(s0_cap), 32'(e0.mosi));
          check("latency0", 32'(cyc - acc0), 32'(L0));
          check("cs0_high_at_done", 32'(cs0), 32'd1);
        end
      end
      if (done1) begin
        n_done1++;
        check("done1_expected", 32'(exp_q1.size() > 0), 32'd1);
        if (exp_q1.size() > 0) begin
          e1 = exp_q1.pop_front();
          check("rx1", 32'(rx1), 32'(e1.rx));
          check("mosi1_bits", 32'(s1_cap), 32'(e1.mosi));
          check("latency1", 32'(cyc - acc1), 32'(L1));
        end
      end
      if (!cs1 && cs1_q) begin
        if (seen1) check("cs1_gap_ge2", 32'(gap1 >= 2), 32'd1);
        seen1 = 1'b1;
      end
      gap1 = cs1 ? gap1 + 1 : 0;
    end
    busy0_q = busy0; busy1_q = busy1; done0_q = done0; done1_q = done1; cs1_q = cs1;
  end

  task automatic expect0(input logic [7:0] tx, input logic [7:0] rsp);
    exp_t e;
    e.mosi = wire_order(tx);
    e.rx   = rsp;
    resp_q0.push_back(rsp);
    exp_q0.push_back(e);
  endtask

  task automatic expect1(input logic [7:0] tx, input logic [7:0] rsp);
    exp_t e;
    e.mosi = wire_order(tx);
    e.rx   = rsp;
    resp_q1.push_back(rsp);
    exp_q1.push_back(e);
  endtask

  task automatic wait_done0(input int target);
    int k = 0;
    while (n_done0 < target && k < 500) begin @(negedge clk); k++; end
    check("done0_timeout", 32'(n_done0 >= target), 32'd1);
    repeat (2) @(negedge clk);
    check("idle0_busy_cs_sclk", 32'({busy0, cs0, sclk0}), 32'b010);
  endtask

  task automatic wait_rises0(input int n);
    int k = 0;
    while (s0_rises < n && k < 300) begin @(negedge clk); k++; end
    check("rises0_timeout", 32'(s0_rises >= n), 32'd1);
  endtask

  task automatic issue0(input logic [7:0] tx, input logic [7:0] rsp);
    int d;
    d = n_done0;
    expect0(tx, rsp);
    @(negedge clk); start0 = 1'b1; data0 = tx;
    @(negedge clk); start0 = 1'b0; data0 = 8'($urandom);
    check("busy0_after_accept", 32'(busy0), 32'd1);
    wait_done0(d + 1);
    repeat (3) @(negedge clk);
    check("rx0_holds", 32'(rx0), 32'(rsp));
  endtask

  // Two transactions with start held high across both.
  task automatic issue1_pair(input logic [7:0] ta, input logic [7:0] ra,
                             input logic [7:0] tb, input logic [7:0] rb);
    int a, d, k;
    a = n_acc1; d = n_done1; k = 0;
    expect1(ta, ra);
    expect1(tb, rb);
    @(negedge clk); start1 = 1'b1; data1 = ta;
    while (n_acc1 < a + 1 && k < 200) begin @(negedge clk); k++; end
    data1 = tb;
    while (n_acc1 < a + 2 && k < 200) begin @(negedge clk); k++; end
    start1 = 1'b0; data1 = 8'($urandom);
    while (n_done1 < d + 2 && k < 400) begin @(negedge clk); k++; end
    check("pair1_done_timeout", 32'(n_done1 >= d + 2), 32'd1);
    repeat (3) @(negedge clk);
    check("pair1_idle_busy_cs", 32'({busy1, cs1}), 32'b01);
  endtask

  initial begin
    int d, a;
    logic [7:0] r;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs0", 32'({sclk0, cs0, mosi0, busy0, done0, rx0}), 32'({5'b01000, 8'h00}));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outs0", 32'({sclk0, cs0, mosi0, busy0, done0, rx0}), 32'({5'b01000, 8'h00}));
    check("post_reset_outs1", 32'({sclk1, cs1, mosi1, busy1, done1, rx1}), 32'({5'b01000, 8'h00}));

    issue0(8'hA5, 8'h3C);

    // start pulsed during the 4th sclk high phase must be ignored.
    d = n_done0; a = n_acc0; r = 8'($urandom);
    expect0(8'h55, r);
    @(negedge clk); start0 = 1'b1; data0 = 8'h55;
    @(negedge clk); start0 = 1'b0;
    wait_rises0(4);
    start0 = 1'b1; data0 = 8'hFF;
    @(negedge clk); start0 = 1'b0; data0 = 8'h00;
    wait_done0(d + 1);
    repeat (60) @(negedge clk);
    check("busy_reject_accepts", 32'(n_acc0), 32'(a + 1));
    check("busy_reject_cs_high", 32'(cs0), 32'd1);

    for (int i = 0; i < 6; i++) issue0(8'($urandom), 8'($urandom));

    // Reset after the 3rd rising sclk: outputs drop at once, no done follows.
    d = n_done0;
    expect0(8'($urandom), 8'($urandom));
    @(negedge clk); start0 = 1'b1; data0 = 8'h96;
    @(negedge clk); start0 = 1'b0;
    wait_rises0(3);
    rst_n = 1'b0;
    #1;
    check("midreset_outs0", 32'({sclk0, cs0, mosi0, busy0, done0}), 32'b01000);
    exp_q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("no_done_after_reset", 32'(n_done0), 32'(d));
    check("rx0_cleared_by_reset", 32'(rx0), 32'd0);
    issue0(8'hC3, 8'($urandom));

    issue0(8'h01, 8'h01);
    issue0(8'h00, 8'hFF);
    issue0(8'hFF, 8'h00);

    issue1_pair(8'hFF, 8'h81, 8'h00, 8'h7E);
    for (int i = 0; i < 2; i++)
      issue1_pair(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    check("cs0_low_during_sclk", 32'(cs_viol0), 32'd0);
    check("cs1_low_during_sclk", 32'(cs_viol1), 32'd0);
    check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
